// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// responder state encoding and the wait-state counter width.
// Pure declarations; no logic, latency or backpressure of its own.
package mem_pkg;

    // Access size encodings carried on req_funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state counter (WAIT_STATES legal range 0..7)
    localparam int WS_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram.sv
// Word-organised data storage with a 4-bit byte-enable write port.
// Latency: read data registered, valid the cycle after an enabled read.
// Backpressure: none; one access per enabled cycle. Contents not reset.
module data_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Load/store responder: accepts one request, checks it, accesses data_ram.
// Latency: rsp_valid from cycle N+1+WAIT_STATES after accept edge N (errors: N+1).
// Backpressure: one outstanding request; req_ready only in IDLE, response held until rsp_ready.
//
// Ports: clk/rst (async active-low); req_* request channel (valid/ready, we,
// byte addr, right-aligned wdata, funct3 size); rsp_* response channel
// (valid/ready, extended rdata, err).
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [WS_W-1:0] CNT_INIT = NO_WAIT ? '0 : WS_W'(WAIT_STATES - 1);

    state_t          state;
    logic [WS_W-1:0] cnt;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic [2:0]      f3_q;

    // In IDLE the live request is checked so a zero-wait access can commit on
    // the accept edge; afterwards the latched copy drives everything.
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_we;
    logic [2:0]  cur_f3;

    assign cur_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata  : wdata_q;
    assign cur_we    = (state == IDLE) ? req_we     : we_q;
    assign cur_f3    = (state == IDLE) ? req_funct3 : f3_q;

    logic        err;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        accept;
    logic        commit;
    logic [31:0] ram_rdata;
    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
        err = 1'b0;
        case (cur_f3)
            F3_B:    err = 1'b0;
            F3_H:    err = cur_addr[0];
            F3_W:    err = |cur_addr[1:0];
            F3_BU:   err = cur_we;
            F3_HU:   err = cur_we | cur_addr[0];
            default: err = 1'b1;
        endcase
        if ({1'b0, cur_addr} >= LIMIT) err = 1'b1;
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        be    = 4'b1111;
        wlane = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << cur_addr[1:0];
                wlane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{cur_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = cur_wdata;
            end
        endcase
    end

    assign accept = (state == IDLE) && req_valid;
    // Only legal requests ever reach WAIT, so the WAIT commit needs no err term.
    assign commit = (accept && NO_WAIT && !err) || ((state == WAIT) && (cnt == '0));

    data_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (commit),
        .we    (cur_we),
        .be    (be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (wlane),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        if (err || NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load extension works on the registered RAM word, which only changes on
    // an enabled read, so the response stays stable for the whole RESP phase.
    assign shifted = ram_rdata >> {cur_addr[1:0], 3'b000};

    always_comb begin
        ext = ram_rdata;
        case (cur_f3)
            F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ext = {24'h0, shifted[7:0]};
            F3_HU:   ext = {16'h0, shifted[15:0]};
            default: ext = ram_rdata;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err;
    assign rsp_rdata = ((state == RESP) && !err && !cur_we) ? ext : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
    import mem_pkg::*;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;

    data_mem_resp #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request, then scramble the request fields while busy; returns
    // the response and the latency in samples (accept-edge sample counts as 1).
    task automatic req_start(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, output logic [31:0] rd, output logic er,
                             output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h44; req_wdata = 32'h5A5A5A5A; req_funct3 = 3'b011;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic rsp_take();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
        chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    endtask

    // Full transaction with checks on data, error flag and latency
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req_start(we, addr, wd, f3, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
        chk({tag, "_lat"}, lat, exp_er ? 32'd1 : 32'(1 + WS));
        rsp_take();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        // Reset values while held in reset
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store / load
        txn("sw_10",  1'b1, 32'h10, 32'h12345678, F3_W,  32'h0, 1'b0);
        txn("lw_10",  1'b0, 32'h10, 32'h0,        F3_W,  32'h12345678, 1'b0);

        // Byte store and byte loads
        txn("sb_11",  1'b1, 32'h11, 32'hFFFFFFAB, F3_B,  32'h0, 1'b0);
        txn("lw_10b", 1'b0, 32'h10, 32'h0,        F3_W,  32'h1234AB78, 1'b0);
        txn("lb_11",  1'b0, 32'h11, 32'h0,        F3_B,  32'hFFFFFFAB, 1'b0);
        txn("lbu_11", 1'b0, 32'h11, 32'h0,        F3_BU, 32'h000000AB, 1'b0);
        txn("lb_10",  1'b0, 32'h10, 32'h0,        F3_B,  32'h00000078, 1'b0);

        // Halfword store and loads
        txn("sh_12",  1'b1, 32'h12, 32'h00008001, F3_H,  32'h0, 1'b0);
        txn("lh_12",  1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFF8001, 1'b0);
        txn("lhu_12", 1'b0, 32'h12, 32'h0,        F3_HU, 32'h00008001, 1'b0);
        txn("lh_10",  1'b0, 32'h10, 32'h0,        F3_H,  32'hFFFFAB78, 1'b0);

        // Error cases: no memory effect, immediate response
        txn("e_lw_13",   1'b0, 32'h13,    32'h0,        F3_W,   32'h0, 1'b1);
        txn("e_sh_01",   1'b1, 32'h01,    32'hFFFF,     F3_H,   32'h0, 1'b1);
        txn("e_sw_oor",  1'b1, 32'h10000, 32'hFFFFFFFF, F3_W,   32'h0, 1'b1);
        txn("e_f3_011",  1'b0, 32'h10,    32'h0,        3'b011, 32'h0, 1'b1);
        txn("e_sbu",     1'b1, 32'h10,    32'h000000EE, F3_BU,  32'h0, 1'b1);
        txn("e_sw_last", 1'b1, 32'h1000,  32'h11111111, F3_W,   32'h0, 1'b1);
        txn("sw_last",   1'b1, 32'hFFC,   32'h0BADF00D, F3_W,   32'h0, 1'b0);
        txn("lw_last",   1'b0, 32'hFFC,   32'h0,        F3_W,   32'h0BADF00D, 1'b0);
        txn("lw_10c",    1'b0, 32'h10,    32'h0,        F3_W,   32'h8001AB78, 1'b0);

        // Response backpressure: held 5 cycles
        req_start(1'b0, 32'h10, 32'h0, F3_W, rd, er, lat);
        chk("bp_rdata0", rd, 32'h8001AB78);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rdata", rsp_rdata, 32'h8001AB78);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_take();

        // Reset during WAIT aborts the store
        txn("sw_20", 1'b1, 32'h20, 32'hCAFEF00D, F3_W, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_funct3 = F3_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort_rsp_rdata", rsp_rdata, 32'h0);
        chk("abort_rsp_err",   {31'h0, rsp_err}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn("lw_20", 1'b0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 1'b0);
        txn("lw_10d", 1'b0, 32'h10, 32'h0, F3_W, 32'h8001AB78, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
